channel_pooling_unit: RTL and testbench
=======================================

CHANNEL_POOLING_UNIT -- requirements
Module: channel_pooling_unit

Interface
REQ-001 The block SHALL have parameter BitSize, default 8, meaning the sample width (signed two's complement).
REQ-002 The block SHALL have parameter ImageWidth, default 16, meaning the input feature-map width and height in pixels (square map).
REQ-003 The block SHALL have parameter NumberOfK, default 8, meaning the channel count.
REQ-004 The block SHALL have parameter ProcessingElements, default 2, meaning the lanes per beat; NumberOfK SHALL be a multiple of it.
REQ-005 The block SHALL have parameter CyclesPerPixel, default NumberOfK/ProcessingElements, meaning the beats per pixel.
REQ-006 The block SHALL have parameter PoolN, default 2, meaning the pooling window side and stride; it SHALL be a power of two dividing ImageWidth, else elaboration fails.
REQ-007 The block SHALL have parameter Mode, default POOL_MAX, meaning the pooling mode of type pool_mode_e.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port res_n, input, 1 bit: the asynchronous active-low reset.
REQ-010 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: input beat accepted when high together with in_valid.
REQ-012 The block SHALL have port in_data, input, [ProcessingElements][BitSize]: lane p of beat b carries channel b*ProcessingElements+p.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-014 The block SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-015 The block SHALL have port out_data, output, [ProcessingElements][BitSize]: pooled lanes in the same lane/beat layout as the input.
REQ-016 The block SHALL have port out_beat, output, clog2(CyclesPerPixel) bits: beat index of out_data.
REQ-017 The block SHALL have port frame_done, output, 1 bit: high with the last output beat of a frame.

Function
REQ-018 Input order SHALL be raster order (row, then column, then beat 0..CyclesPerPixel-1); beat/col/row counters SHALL advance only on an accepted beat (in_valid && in_ready).
REQ-019 in_ready SHALL equal !out_valid || out_ready; in_ready is combinational and the only stall path.
REQ-020 Partial-result storage SHALL hold (ImageWidth/PoolN)*NumberOfK entries, indexed by (col/PoolN, channel).
REQ-021 At window position (row%PoolN==0, col%PoolN==0) the entry SHALL be loaded; at any other position it SHALL be combined with the stored value.
REQ-022 For POOL_MAX the combine SHALL be a signed maximum; for POOL_AVG it SHALL be a signed sum in BitSize+2*log2(PoolN) bits with no overflow.
REQ-023 At window position (PoolN-1, PoolN-1) the combined value SHALL be emitted, not stored: max as-is; average as the sum arithmetically right-shifted by 2*log2(PoolN) (floor).
REQ-024 An emitted beat SHALL appear on out_data/out_valid one cycle after acceptance; out_beat SHALL equal the input beat index.
REQ-025 out_valid SHALL hold, and out_data/out_beat SHALL remain stable, until out_ready is high; on the same cycle a new emission MAY replace it (back-to-back, no bubble).
REQ-026 frame_done SHALL be high exactly while the output beat from row=col=ImageWidth-1, beat=CyclesPerPixel-1 is valid; counters SHALL wrap to 0 so the next frame follows with no idle cycle.
REQ-027 Each frame SHALL produce (ImageWidth/PoolN)^2 * CyclesPerPixel output beats.

Reset
REQ-028 On res_n low the block SHALL asynchronously clear all counters, out_valid, out_data, out_beat and frame_done to 0; storage contents need not be cleared.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; the first accepted beat after release SHALL be treated as row 0, col 0, beat 0.

Configuration
REQ-030 With macro POOL_AVG_EN defined, both modes SHALL be supported per Mode.
REQ-031 Without POOL_AVG_EN, only POOL_MAX SHALL be built, storage width SHALL be BitSize, and Mode=POOL_AVG SHALL fail elaboration.

Structure
REQ-032 Package pool_pkg SHALL hold pool_mode_e (POOL_MAX, POOL_AVG) and the accumulator-width function.
REQ-033 Sub-module pool_combine SHALL implement the per-lane load/combine/finalise datapath, instantiated ProcessingElements times.

Verification
REQ-034 Defaults with max mode, channel k of pixel (r,c) = r*16+c-128: output channel k of pooled (i,j) = 32i+2j-111, 64 pixels x 4 beats, frame_done on the 256th beat.
REQ-035 Avg mode, one 2x2 window with inputs -1, -2, 1, 1: output is -1 (sum -1 floored), not 0.
REQ-036 out_ready held low for 5 cycles at an emission: in_ready=0, out_data stable, no accepted beat lost, count still 256.
REQ-037 res_n pulsed low at row 5 col 3 beat 2: outputs 0 immediately; a following full frame matches REQ-034 exactly.
REQ-038 Two frames back-to-back with in_valid constantly high and out_ready=1: 512 output beats, two frame_done pulses 256 beats apart.

Source files
------------

// File: rtl/channel_pooling_unit_pkg.sv
// pool_pkg: shared types and width helpers for channel_pooling_unit.
// Contents: pool_mode_e (POOL_MAX, POOL_AVG), acc_width() for the average
// accumulator, idx_width() for counters/indices that must be at least 1 bit.
package pool_pkg;

    typedef enum logic {
        POOL_MAX,
        POOL_AVG
    } pool_mode_e;

    // A PoolN x PoolN sum grows by log2(PoolN*PoolN) bits.
    function automatic int acc_width(input int bit_size, input int pool_n);
        return bit_size + 2 * $clog2(pool_n);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_pooling_unit_if.sv
// channel_pooling_unit_if: input/output beat streams of channel_pooling_unit.
// Signals: in_valid/in_ready/in_data (upstream beat), out_valid/out_ready/
// out_data/out_beat (pooled beat), frame_done (last beat of a frame).
// Modports: master drives the input stream and out_ready; slave is the pooler.
interface channel_pooling_unit_if #(
    parameter int BitSize            = 8,
    parameter int ProcessingElements = 2,
    parameter int CyclesPerPixel     = 4
);

    localparam int BeatW = pool_pkg::idx_width(CyclesPerPixel);

    logic                                         in_valid;
    logic                                         in_ready;
    logic [ProcessingElements-1:0][BitSize-1:0]   in_data;
    logic                                         out_ready;
    logic                                         out_valid;
    logic [ProcessingElements-1:0][BitSize-1:0]   out_data;
    logic [BeatW-1:0]                             out_beat;
    logic                                         frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_beat, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_beat, frame_done
    );

endinterface

// File: rtl/channel_pooling_unit_combine.sv
// pool_combine: one lane of the pooling datapath (load / combine / finalise).
// Ports: sample_i new sample, stored_i partial result, load_i first window
// position, comb_o value to store back, result_o finalised pooled sample.
// Average mode is only built when POOL_AVG_EN is defined.
module pool_combine
    import pool_pkg::*;
#(
    parameter int         BitSize = 8,
    parameter int         AccW    = 8,
    parameter int         Shift   = 2,
    parameter pool_mode_e Mode    = POOL_MAX
) (
    input  logic [BitSize-1:0] sample_i,
    input  logic [AccW-1:0]    stored_i,
    input  logic               load_i,
    output logic [AccW-1:0]    comb_o,
    output logic [BitSize-1:0] result_o
);

    logic signed [AccW-1:0] x;
    logic signed [AccW-1:0] s;
    logic signed [AccW-1:0] c;

    assign x      = AccW'($signed(sample_i));
    assign s      = $signed(stored_i);
    assign comb_o = c;

`ifdef POOL_AVG_EN
    assign c        = load_i ? x : (Mode == POOL_AVG) ? x + s : (x > s) ? x : s;
    // Arithmetic shift floors the average towards minus infinity.
    assign result_o = (Mode == POOL_AVG) ? BitSize'(c >>> Shift) : c[BitSize-1:0];
`else
    assign c        = load_i ? x : (x > s) ? x : s;
    assign result_o = c[BitSize-1:0];
`endif

endmodule

// File: rtl/channel_pooling_unit.sv
// channel_pooling_unit: streaming PoolN x PoolN max/average pooling over a
// square multi-channel feature map delivered in raster order, one pixel as
// CyclesPerPixel beats of ProcessingElements lanes.
// Ports: clk, res_n (async active-low), bus (channel_pooling_unit_if.slave).
// Optional macro POOL_AVG_EN enables Mode=POOL_AVG; without it only max pooling.
module channel_pooling_unit
    import pool_pkg::*;
#(
    parameter int         BitSize            = 8,
    parameter int         ImageWidth         = 16,
    parameter int         NumberOfK          = 8,
    parameter int         ProcessingElements = 2,
    parameter int         CyclesPerPixel     = NumberOfK / ProcessingElements,
    parameter int         PoolN              = 2,
    parameter pool_mode_e Mode               = POOL_MAX
) (
    input logic                   clk,
    input logic                   res_n,
    channel_pooling_unit_if.slave bus
);

    localparam int PoolLog = $clog2(PoolN);
    localparam int Shift   = 2 * PoolLog;
`ifdef POOL_AVG_EN
    localparam int AccW    = (Mode == POOL_AVG) ? acc_width(BitSize, PoolN) : BitSize;
`else
    localparam int AccW    = BitSize;
`endif
    localparam int CW      = idx_width(ImageWidth);
    localparam int BW      = idx_width(CyclesPerPixel);
    localparam int Depth   = (ImageWidth / PoolN) * CyclesPerPixel;
    localparam int IW      = idx_width(Depth);

    if ((1 << PoolLog) != PoolN || ImageWidth % PoolN != 0) begin : g_bad_pool
        $fatal(1, "PoolN must be a power of two dividing ImageWidth");
    end
    if (CyclesPerPixel * ProcessingElements != NumberOfK) begin : g_bad_lanes
        $fatal(1, "NumberOfK must equal CyclesPerPixel * ProcessingElements");
    end
`ifndef POOL_AVG_EN
    if (Mode == POOL_AVG) begin : g_no_avg
        $fatal(1, "Mode POOL_AVG requires POOL_AVG_EN");
    end
`endif

    logic [BW-1:0]                               beat_q, beat_d;
    logic [CW-1:0]                               col_q, col_d;
    logic [CW-1:0]                               row_q, row_d;
    logic                                        out_valid_q, out_valid_d;
    logic [ProcessingElements-1:0][BitSize-1:0]  out_data_q, out_data_d;
    logic [BW-1:0]                               out_beat_q, out_beat_d;
    logic                                        frame_done_q, frame_done_d;
    logic [ProcessingElements-1:0][AccW-1:0]     mem_q [Depth];
    logic [ProcessingElements-1:0][AccW-1:0]     stored;
    logic [ProcessingElements-1:0][AccW-1:0]     comb;
    logic [ProcessingElements-1:0][BitSize-1:0]  result;
    logic [IW-1:0]                               idx;
    logic                                        accept;
    logic                                        emit;
    logic                                        load;
    logic                                        last;
    logic                                        beat_end;
    logic                                        col_end;
    logic                                        row_end;
    logic [CW-1:0]                               win_mask;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign beat_end       = beat_q == BW'(CyclesPerPixel - 1);
    assign col_end        = col_q == CW'(ImageWidth - 1);
    assign row_end        = row_q == CW'(ImageWidth - 1);
    assign win_mask       = CW'(PoolN - 1);
    assign load           = (row_q & win_mask) == '0 && (col_q & win_mask) == '0;
    assign last           = (row_q & win_mask) == win_mask && (col_q & win_mask) == win_mask;
    assign emit           = accept && last;
    // One storage word per (pooled column, beat) holds all lanes of that beat.
    assign idx            = IW'(col_q >> PoolLog) * IW'(CyclesPerPixel) + IW'(beat_q);
    assign stored         = mem_q[idx];

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_beat   = out_beat_q;
    assign bus.frame_done = frame_done_q;

    for (genvar p = 0; p < ProcessingElements; p++) begin : g_lane
        pool_combine #(
            .BitSize (BitSize),
            .AccW    (AccW),
            .Shift   (Shift),
            .Mode    (Mode)
        ) u_combine (
            .sample_i (bus.in_data[p]),
            .stored_i (stored[p]),
            .load_i   (load),
            .comb_o   (comb[p]),
            .result_o (result[p])
        );
    end

    always_comb begin
        beat_d       = !accept ? beat_q : beat_end ? '0 : beat_q + 1'b1;
        col_d        = !(accept && beat_end) ? col_q : col_end ? '0 : col_q + 1'b1;
        row_d        = !(accept && beat_end && col_end) ? row_q : row_end ? '0 : row_q + 1'b1;
        out_valid_d  = emit || (out_valid_q && !bus.out_ready);
        out_data_d   = emit ? result : out_data_q;
        out_beat_d   = emit ? beat_q : out_beat_q;
        frame_done_d = emit ? (beat_end && col_end && row_end) : (frame_done_q && !bus.out_ready);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            beat_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_beat_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_beat_q   <= out_beat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Partial results need no reset: every window starts with a load.
    always_ff @(posedge clk) begin
        if (accept && !last) mem_q[idx] <= comb;
    end

endmodule

// File: tb/tb_channel_pooling_unit.sv
// tb_channel_pooling_unit: directed bench for channel_pooling_unit (defaults,
// max mode) plus an average-mode instance when POOL_AVG_EN is defined.
module tb_channel_pooling_unit;
    import pool_pkg::*;

    logic clk;
    logic res_n;
    int   n_tests;
    int   n_fail;
    int   out_cnt;
    int   base;
    int   nfd;
    int   fd_pos[$];
    logic [31:0] exp_q[$];
    logic [31:0] e_front;

    channel_pooling_unit_if #(.BitSize(8), .ProcessingElements(2), .CyclesPerPixel(4)) bus ();

    channel_pooling_unit #(
        .BitSize(8), .ImageWidth(16), .NumberOfK(8), .ProcessingElements(2),
        .CyclesPerPixel(4), .PoolN(2), .Mode(POOL_MAX)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

`ifdef POOL_AVG_EN
    channel_pooling_unit_if #(.BitSize(8), .ProcessingElements(1), .CyclesPerPixel(1)) abus ();

    channel_pooling_unit #(
        .BitSize(8), .ImageWidth(2), .NumberOfK(1), .ProcessingElements(1),
        .CyclesPerPixel(1), .PoolN(2), .Mode(POOL_AVG)
    ) adut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (abus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output scoreboard: a beat is consumed on the edge following a negedge
    // where out_valid && out_ready.
    always @(negedge clk) begin
        if (res_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {13'b0, bus.frame_done, bus.out_beat, bus.out_data}, 32'hffffffff);
            end else begin
                e_front = exp_q.pop_front();
                check("out", {13'b0, bus.frame_done, bus.out_beat, bus.out_data}, e_front);
            end
            out_cnt++;
            if (bus.frame_done) fd_pos.push_back(out_cnt);
        end
    end

    task automatic drive_beat(input logic [15:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic abort_reset();
        #1;
        res_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", {16'b0, bus.out_data}, 32'd0);
        check("rst_out_beat", {30'b0, bus.out_beat}, 32'd0);
        check("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // pat 0: every channel = r*16+c-128, pooled max = 32i+2j-111.
    // pat 1: channel k = ((r*16+c)>>1)-64+k, pooled max = 16i+j-56+k.
    task automatic send_frame(input int pat, input bit abort);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                for (int b = 0; b < 4; b++) begin
                    logic [15:0] d;
                    logic [15:0] ev;
                    int v;
                    int k;
                    if (abort && r == 5 && c == 3 && b == 2) begin
                        abort_reset();
                        return;
                    end
                    for (int p = 0; p < 2; p++) begin
                        k = b * 2 + p;
                        v = (pat == 0) ? r * 16 + c - 128 : ((r * 16 + c) >> 1) - 64 + k;
                        d[p*8 +: 8] = v[7:0];
                        v = (pat == 0) ? 32 * (r / 2) + 2 * (c / 2) - 111 : 16 * (r / 2) + (c / 2) - 56 + k;
                        ev[p*8 +: 8] = v[7:0];
                    end
                    drive_beat(d);
                    if (r % 2 == 1 && c % 2 == 1) begin
                        exp_q.push_back({13'b0, (r == 15 && c == 15 && b == 3), 2'(b), ev});
                        check("latency_valid", {31'b0, bus.out_valid}, 32'd1);
                    end
                end
            end
        end
    endtask

    task automatic stall_out();
        int n = 0;
        logic [15:0] hold;
        while (out_cnt < base + 10 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        hold = (exp_q.size() != 0) ? exp_q[0][15:0] : 16'hxxxx;
        repeat (5) begin
            check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stall_out_data", {16'b0, bus.out_data}, {16'b0, hold});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

`ifdef POOL_AVG_EN
    task automatic avg_window(input string tag, input int v0, input int v1, input int v2, input int v3, input int e);
        int vals[4];
        logic [7:0] e8;
        vals = '{v0, v1, v2, v3};
        e8 = e[7:0];
        for (int i = 0; i < 4; i++) begin
            abus.in_valid = 1'b1;
            abus.in_data  = vals[i][7:0];
            @(posedge clk);
            #1;
        end
        abus.in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, abus.out_valid}, 32'd1);
        check(tag, {24'b0, abus.out_data}, {24'b0, e8});
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        out_cnt = 0;
        base    = 0;
        res_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef POOL_AVG_EN
        abus.in_valid  = 1'b0;
        abus.in_data   = '0;
        abus.out_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_out_data", {16'b0, bus.out_data}, 32'd0);
        check("reset_out_beat", {30'b0, bus.out_beat}, 32'd0);
        check("reset_frame_done", {31'b0, bus.frame_done}, 32'd0);
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        base = out_cnt;
        fork
            send_frame(0, 1'b0);
            stall_out();
        join
        bus.in_valid = 1'b0;
        wait_drain();
        check("frame_stall_count", out_cnt - base, 32'd256);

        send_frame(0, 1'b1);
        base = out_cnt;
        send_frame(0, 1'b0);
        bus.in_valid = 1'b0;
        wait_drain();
        check("frame_after_reset_count", out_cnt - base, 32'd256);

        base = out_cnt;
        nfd  = fd_pos.size();
        send_frame(1, 1'b0);
        send_frame(0, 1'b0);
        bus.in_valid = 1'b0;
        wait_drain();
        check("b2b_count", out_cnt - base, 32'd512);
        check("b2b_frame_done_pulses", fd_pos.size() - nfd, 32'd2);
        if (fd_pos.size() >= nfd + 2)
            check("b2b_frame_done_gap", fd_pos[nfd+1] - fd_pos[nfd], 32'd256);
        else
            check("b2b_frame_done_gap", 32'd0, 32'd256);

`ifdef POOL_AVG_EN
        avg_window("avg_floor", -1, -2, 1, 1, -1);
        avg_window("avg_pos_max", 127, 127, 127, 127, 127);
        avg_window("avg_neg_min", -128, -128, -128, -128, -128);
        avg_window("avg_trunc", 1, 1, 1, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
